fd_inst_queue: RTL
==================

// Module: fd_inst_queue
// PURPOSE
//   Decode-side consumer of the fetch stage: a small instruction queue that sits
//   between the fetch outputs (Instr/PC4/PC) and the decode stage.
//   - Buffers fetched entries in order.
//   - Back-pressures fetch through ReadyF, which is wired to the fetch PC enable.
//   - Presents the head entry to decode, with a flush for branch/jump redirects.
// PARAMETERS
//   DEPTH   4   number of entries; power of two, >= 2
//   PTR_W   2   log2(DEPTH); read/write pointer width
// PORTS
//   Clk      in   1        clock, rising edge
//   Reset    in   1        asynchronous, active-high reset
//   ValidF   in   1        fetch offers {InstrF, PC4F, PCF} this cycle
//   InstrF   in   32       fetched instruction
//   PC4F     in   32       PC+4 of the fetched instruction
//   PCF      in   32       PC of the fetched instruction
//   ReadyF   out  1        queue can accept an entry (drives fetch PCEn)
//   StallD   in   1        decode cannot consume the head this cycle
//   Flush    in   1        redirect; discard every buffered entry
//   ValidD   out  1        head entry is valid
//   InstrD   out  32       head instruction; 32'h0 (nop) when ValidD=0
//   PC4D     out  32       head PC+4; 32'h0 when ValidD=0
//   PCD      out  32       head PC; 32'h0 when ValidD=0
//   Count    out  PTR_W+1  number of valid entries, 0..DEPTH
// BEHAVIOUR
//   - Storage is a circular buffer with rd_ptr, wr_ptr (PTR_W bits) and a
//     count register (PTR_W+1 bits). Pointers wrap modulo DEPTH.
//   - Reset (async, takes effect immediately):
//     - rd_ptr = wr_ptr = count = 0; all storage = 0.
//     - Outputs: ReadyF=1, ValidD=0, InstrD=PC4D=PCD=0, Count=0.
//   - Combinational status:
//     - ReadyF = (count != DEPTH). No pass-through: a full queue never accepts,
//       even when decode consumes in the same cycle.
//     - ValidD = (count != 0).
//     - InstrD/PC4D/PCD = the head slot when ValidD=1, else 0.
//   - Cycle qualifiers:
//     - enq = ValidF & ReadyF & ~Flush
//     - deq = ValidD & ~StallD & ~Flush
//   - On each rising edge, in priority order:
//     - Flush=1: rd_ptr=wr_ptr=count=0. Any entry offered in the same cycle is
//       dropped. Storage contents are don't-care.
//     - Otherwise:
//       - enq: write {InstrF, PC4F, PCF} at wr_ptr; wr_ptr+1.
//       - deq: rd_ptr+1.
//       - count += enq - deq. Simultaneous enq and deq leaves count unchanged.
//   - Latency: an entry enqueued at edge N is visible on the D outputs after
//     edge N, provided the queue was empty. There is no same-cycle bypass.
//   - Order: entries leave strictly in arrival order, with no loss or
//     duplication across pointer wrap-around.
//   - Boundaries:
//     - Full: ReadyF=0, and fetch must hold its PC.
//     - Empty: StallD is ignored and the outputs show a nop bubble.
//     - Full with deq: count becomes DEPTH-1 and ReadyF=1 in the next cycle.
//   - Flush has priority over both StallD and ValidF.
//   - The controller re-fetches any branch delay slot after a redirect; the
//     queue never retains entries across a Flush.
//   - Reset asserted mid-operation discards all contents asynchronously,
//     regardless of Flush or StallD.
// TESTING
//   1. Assert Reset -> immediately ValidD=0, InstrD=PCD=PC4D=0, ReadyF=1,
//      Count=0.
//   2. StallD=1; offer PCF=0x3000,0x3004,0x3008,0x300c,0x3010 (InstrF=0x24010001+i).
//      -> Count=4, ReadyF=0, 0x3010 not accepted; PCD=0x3000,
//         InstrD=0x24010001, PC4D=0x3004.
//   3. Release StallD; stream 8 entries with ValidF=1.
//      -> PCD sequence 0x3000,0x3004,...; no gaps or repeats across pointer wrap.
//   4. Count=2; ValidF=1 and StallD=0 in the same cycle.
//      -> Count stays 2; head advances by one entry.
//   5. Count=3, ValidF=1, Flush=1 for one cycle.
//      -> next cycle Count=0, ValidD=0, InstrD=0; the offered entry is absent.
//   6. Count=3; raise Reset between clock edges.
//      -> Count=0 and ValidD=0 before the next edge; normal enq resumes after
//         Reset falls.

Source files
------------

// File: rtl/fd_inst_queue.sv
// In-order instruction queue between fetch and decode.
// Back-pressures fetch through ReadyF; Flush discards every buffered entry.
module fd_inst_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             ValidF,
    input  logic [31:0]      InstrF,
    input  logic [31:0]      PC4F,
    input  logic [31:0]      PCF,
    output logic             ReadyF,
    input  logic             StallD,
    input  logic             Flush,
    output logic             ValidD,
    output logic [31:0]      InstrD,
    output logic [31:0]      PC4D,
    output logic [31:0]      PCD,
    output logic [PTR_W:0]   Count
);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [31:0] pc;
    } entry_t;

    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic               enq, deq;
    entry_t             head;

    // A full queue never accepts, even if decode drains in the same cycle.
    assign ReadyF = (count_q != FULL);
    assign ValidD = (count_q != '0);
    assign Count  = count_q;

    assign enq = ValidF & ReadyF & ~Flush;
    assign deq = ValidD & ~StallD & ~Flush;

    assign head   = mem_q[rd_ptr_q];
    assign InstrD = ValidD ? head.instr : 32'h0;
    assign PC4D   = ValidD ? head.pc4   : 32'h0;
    assign PCD    = ValidD ? head.pc    : 32'h0;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (Flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) begin
                mem_d[wr_ptr_q] = '{instr: InstrF, pc4: PC4F, pc: PCF};
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
